// File: rtl/ti_affine_pipe.sv
// rtl/ti_affine_pipe.sv - shared nibble-wise affine layer with elastic valid/ready register pipeline
module ti_affine_pipe #(
  parameter int NSHARES = 3,
  parameter int NIBBLES = 16,
  parameter int STAGES  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_mode,
  input  logic [NSHARES*NIBBLES*4-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NSHARES*NIBBLES*4-1:0] out_data,
  output logic                         busy
);

  localparam int         SW    = NIBBLES * 4;
  localparam int         W     = NSHARES * SW;
  localparam logic [3:0] AFF_C = 4'hE;

  // Mapped beat entering stage 0 and the upstream view of every stage
  logic [W-1:0]      w_mapped;
  logic [STAGES-1:0] w_up_v;
  logic [W-1:0]      w_up_d [STAGES];

  // Ready chain
  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_load;
  logic              w_full_above;

  // Stage state
  logic [STAGES-1:0] r_v;
  logic [W-1:0]      r_data [STAGES];

  // Linear part of the map; identical for every share so the sharing stays correct
  function automatic logic [3:0] f_lin(input logic [3:0] i);
    f_lin = {i[3] ^ i[2] ^ i[1],
             i[3] ^ i[2] ^ i[0],
             i[3] ^ i[2] ^ i[1] ^ i[0],
             i[2] ^ i[0]};
  endfunction

  // Per-nibble map; the affine constant is injected only where add_c is set (share 0)
  function automatic logic [3:0] f_map(input logic [3:0] i, input logic [1:0] mode, input logic add_c);
    case (mode)
      2'd1:    f_map = f_lin(i) ^ (add_c ? AFF_C : 4'h0);
      2'd2:    f_map = f_lin(i);
      default: f_map = i;
    endcase
  endfunction

  // Combinational map of every nibble of every share, registered into stage 0
  always_comb begin
    w_mapped = '0;
    for (int s = 0; s < NSHARES; s++) begin
      for (int n = 0; n < NIBBLES; n++) begin
        w_mapped[s*SW + n*4 +: 4] = f_map(in_data[s*SW + n*4 +: 4], in_mode, (s == 0));
      end
    end
  end

  // Upstream valid/data for each stage: the input beat for stage 0, the previous stage otherwise
  always_comb begin
    w_up_v    = '0;
    w_up_v[0] = in_valid;
    w_up_d[0] = w_mapped;
    for (int k = 1; k < STAGES; k++) begin
      w_up_v[k] = r_v[k-1];
      w_up_d[k] = r_data[k-1];
    end
  end

  // Backward ready chain: a stage advances when any later stage is empty or the sink accepts
  always_comb begin
    w_full_above = 1'b1;
    w_adv        = '0;
    w_load       = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_adv[k]     = out_ready | ~w_full_above;
      w_load[k]    = ~r_v[k] | w_adv[k];
      w_full_above = w_full_above & r_v[k];
    end
  end

  // Stage registers: data captured only under a valid upstream beat so stalled shares never toggle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_v[k] <= w_up_v[k];
          if (w_up_v[k]) begin
            r_data[k] <= w_up_d[k];
          end
        end
      end
    end
  end

  assign in_ready  = w_load[0];
  assign out_valid = r_v[STAGES-1];
  assign out_data  = r_data[STAGES-1];
  assign busy      = |r_v;

endmodule

// File: tb/tb_ti_affine_pipe.sv
// tb/tb_ti_affine_pipe.sv - scoreboard bench for ti_affine_pipe
module tb_ti_affine_pipe;

  localparam int         NS     = 3;
  localparam int         NB     = 16;
  localparam int         ST     = 3;
  localparam int         SW     = NB * 4;
  localparam int         W      = NS * SW;
  localparam int         NBEATS = 10000;
  // Input-bit masks of L0..L3 (L_j = parity of i & mask_j)
  localparam logic [15:0] LMASK = 16'b1110_1101_1111_0101;
  localparam logic [3:0]  ACONST = 4'hE;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_mode = 2'd0;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         busy;

  typedef struct {
    logic [W-1:0]  exp;
    logic [SW-1:0] exp_ux;
    int            acc;
    bit            lat;
  } sb_t;

  sb_t          sbq[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           acc_cnt = 0;
  int           out_cnt = 0;
  bit           chk_lat = 1'b0;
  bit           stall_prev = 1'b0;
  logic [W-1:0] stall_data = '0;

  ti_affine_pipe #(.NSHARES(NS), .NIBBLES(NB), .STAGES(ST)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [3:0] m_lin(input logic [3:0] x);
    logic [3:0] r;
    for (int j = 0; j < 4; j++) r[j] = ^(x & LMASK[j*4 +: 4]);
    return r;
  endfunction

  function automatic logic [3:0] m_nib(input logic [3:0] x, input logic [1:0] mode, input bit s0);
    if (mode == 2'd1) return m_lin(x) ^ (s0 ? ACONST : 4'h0);
    if (mode == 2'd2) return m_lin(x);
    return x;
  endfunction

  function automatic logic [W-1:0] m_beat(input logic [W-1:0] d, input logic [1:0] mode);
    logic [W-1:0] r;
    r = '0;
    for (int s = 0; s < NS; s++)
      for (int n = 0; n < NB; n++)
        r[s*SW + n*4 +: 4] = m_nib(d[s*SW + n*4 +: 4], mode, (s == 0));
    return r;
  endfunction

  function automatic logic [SW-1:0] unshare(input logic [W-1:0] d);
    logic [SW-1:0] r;
    r = '0;
    for (int s = 0; s < NS; s++) r ^= d[s*SW +: SW];
    return r;
  endfunction

  // Map applied to the recombined secret: the constant appears exactly once
  function automatic logic [SW-1:0] m_plain(input logic [SW-1:0] x, input logic [1:0] mode);
    logic [SW-1:0] r;
    r = '0;
    for (int n = 0; n < NB; n++) r[n*4 +: 4] = m_nib(x[n*4 +: 4], mode, 1'b1);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_beat();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Acceptor: every handshake decided at this edge pushes its modelled response
  always @(negedge clk) begin
    sb_t e;
    if (rst_n && in_valid && in_ready) begin
      e.exp    = m_beat(in_data, in_mode);
      e.exp_ux = m_plain(unshare(in_data), in_mode);
      e.acc    = cyc;
      e.lat    = chk_lat;
      sbq.push_back(e);
      acc_cnt++;
    end
  end

  // Monitor: pops on every output handshake and checks stall stability
  always @(negedge clk) begin
    sb_t e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_int("stall_valid_hold", int'(out_valid), 1);
        check("stall_data_hold", out_data, stall_data);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat actual=%h required=none", out_data);
        end else begin
          e = sbq.pop_front();
          check("beat_data", out_data, e.exp);
          check("beat_unshared", W'(unshare(out_data)), W'(e.exp_ux));
          if (e.lat) check_int("latency", cyc - e.acc, ST);
          out_cnt++;
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  task automatic offer(input logic [W-1:0] d, input logic [1:0] m);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    @(negedge clk);
    while (!in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL offer_timeout actual=in_ready_low required=accept");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_int({name, "_valid"}, int'(out_valid), 1);
    check(name, out_data, exp);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_int("drain_empty", sbq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] e;
    logic [W-1:0] allE;
    logic [W-1:0] b [5];
    int base;
    int idx;
    int vcnt;
    bit done;

    repeat (3) @(posedge clk);
    #1;
    check_int("rst_out_valid", int'(out_valid), 0);
    check_int("rst_busy", int'(busy), 0);
    check("rst_out_data", out_data, '0);
    rst_n = 1'b1;
    #1;
    check_int("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    chk_lat   = 1'b1;

    // Mode 1, share0 nibbles 1, other shares zero
    d = '0;
    e = '0;
    for (int n = 0; n < NB; n++) begin
      d[n*4 +: 4] = 4'h1;
      e[n*4 +: 4] = 4'h9;
    end
    offer(d, 2'd1);
    expect_out("t1_affine", e);

    // Mode 1, shares 5/3/6 recombine to 0; outputs 6/D/5 recombine to E
    allE = '0;
    for (int n = 0; n < NB; n++) begin
      d[n*4 +: 4]          = 4'h5;
      d[SW + n*4 +: 4]     = 4'h3;
      d[2*SW + n*4 +: 4]   = 4'h6;
      e[n*4 +: 4]          = 4'h6;
      e[SW + n*4 +: 4]     = 4'hD;
      e[2*SW + n*4 +: 4]   = 4'h5;
      allE[n*4 +: 4]       = 4'hE;
    end
    offer(d, 2'd1);
    expect_out("t2_shares", e);
    check("t2_unshared", W'(unshare(out_data)), allE);

    // Mode 2, unshared F: L(F) = C with no constant
    d = '0;
    e = '0;
    for (int n = 0; n < NB; n++) begin
      d[n*4 +: 4] = 4'hF;
      e[n*4 +: 4] = 4'hC;
    end
    offer(d, 2'd2);
    expect_out("t3_linear", e);

    // Mode 0 and reserved mode 3 pass data unchanged
    d = rand_beat();
    d[SW-1:0] = 64'h0123456789ABCDEF;
    offer(d, 2'd0);
    expect_out("t3_bypass", d);
    d = rand_beat();
    offer(d, 2'd3);
    expect_out("t3_mode3", d);
    drain();

    // Back-pressure: 5 beats offered into a stalled 3-stage pipe
    out_ready = 1'b0;
    chk_lat   = 1'b0;
    base      = acc_cnt;
    for (int i = 0; i < 5; i++) b[i] = rand_beat();
    for (int c = 0; c < 8; c++) begin
      idx = acc_cnt - base;
      if (idx < 5) begin
        in_valid = 1'b1;
        in_data  = b[idx];
        in_mode  = 2'(idx % 3);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    check_int("t4_accepted", acc_cnt - base, 3);
    check_int("t4_in_ready", int'(in_ready), 0);
    check_int("t4_busy", int'(busy), 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    check_int("t4_release_beats", vcnt, 3);
    drain();

    // Random traffic against the model
    base = out_cnt;
    done = 1'b0;
    fork
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
      end
      begin
        for (int i = 0; i < NBEATS; i++) begin
          while ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          offer(rand_beat(), 2'($urandom_range(0, 3)));
        end
        done = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();
    check_int("t5_beats_out", out_cnt - base, NBEATS);

    // Reset with two beats in flight
    out_ready = 1'b0;
    offer(rand_beat(), 2'd1);
    offer(rand_beat(), 2'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check_int("t6_out_valid", int'(out_valid), 0);
    check_int("t6_busy", int'(busy), 0);
    check("t6_out_data", out_data, '0);
    sbq.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_int("t6_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    chk_lat   = 1'b1;
    base      = out_cnt;
    offer(rand_beat(), 2'd1);
    drain();
    check_int("t6_first_beat", out_cnt - base, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
